// File: rtl/game_nxn_pkg.sv
// Shared types for the NxN game-state block: status codes, FSM states, scan directions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_nxn_pkg;

  // Encoding seen by the display/control logic on game_status.
  typedef enum logic [2:0] {
    X_TURN = 3'b000,
    O_TURN = 3'b001,
    X_WIN  = 3'b010,
    O_WIN  = 3'b011,
    DRAW   = 3'b100
  } status_t;

  typedef enum logic [2:0] {
    X_WAIT,
    O_WAIT,
    AI_WAIT,
    SCAN,
    DONE
  } fsm_t;

  typedef enum logic {
    MOVER_X = 1'b0,
    MOVER_O = 1'b1
  } mover_t;

  // Bit positions in the line checker's per-direction hit vector.
  localparam int DIR_RIGHT  = 0;
  localparam int DIR_DOWN   = 1;
  localparam int DIR_DIAG_R = 2;  // down-right
  localparam int DIR_DIAG_L = 3;  // down-left
  localparam int NUM_DIRS   = 4;

  function automatic status_t win_status(input mover_t m);
    return (m == MOVER_O) ? O_WIN : X_WIN;
  endfunction

endpackage

// File: rtl/game_state_nxn_if.sv
// Player/AI move port and board/status outputs of the NxN game-state block.
// Latency: n/a (wiring only).
// Backpressure: AI side is request/valid (ai_req gates ai_move_valid); player side is edge-strobed.
interface game_state_nxn_if #(
  parameter int N  = 3,
  parameter int IW = $clog2(N*N)
);
  localparam int CELLS = N*N;

  logic             move;
  logic [IW-1:0]    next_move;
  logic             ai_enable;
  logic             ai_move_valid;
  logic [IW-1:0]    ai_move;
  logic             ai_req;
  logic [CELLS-1:0] x_state;
  logic [CELLS-1:0] o_state;
  logic [2:0]       game_status;
  logic             busy;
  logic             move_reject;

  // Player / AI engine side.
  modport master (
    output move, next_move, ai_enable, ai_move_valid, ai_move,
    input  ai_req, x_state, o_state, game_status, busy, move_reject
  );

  // Game-state block side.
  modport slave (
    input  move, next_move, ai_enable, ai_move_valid, ai_move,
    output ai_req, x_state, o_state, game_status, busy, move_reject
  );

endinterface

// File: rtl/game_state_nxn_line_checker.sv
// Tests the four K-long lines (right, down, down-right, down-left) starting at one cell.
// Latency: combinational.
// Backpressure: none.
module line_checker
  import game_nxn_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int SW = $clog2(N*N) + 1
) (
  input  logic [N*N-1:0]      board,
  input  logic [SW-1:0]       start,
  output logic [NUM_DIRS-1:0] hit
);

  localparam int CELLS = N*N;

  int   s;
  int   row;
  int   col;
  logic in_range;
  logic fits_r;
  logic fits_d;
  logic fits_l;

  // Indices past the board read as empty, so out-of-board lines never hit.
  function automatic logic cell_at(input logic [CELLS-1:0] b, input int idx);
    logic [CELLS-1:0] sh;
    sh = b >> idx;
    return sh[0];
  endfunction

  // A line only counts if all K cells fit without wrapping rows; then AND along it.
  always_comb begin
    s        = int'(start);
    row      = s / N;
    col      = s % N;
    in_range = (s < CELLS);
    fits_r   = (col + K <= N);
    fits_d   = (row + K <= N);
    fits_l   = (col >= K - 1);
    hit[DIR_RIGHT]  = in_range && fits_r;
    hit[DIR_DOWN]   = in_range && fits_d;
    hit[DIR_DIAG_R] = in_range && fits_r && fits_d;
    hit[DIR_DIAG_L] = in_range && fits_l && fits_d;
    for (int j = 0; j < K; j++) begin
      hit[DIR_RIGHT]  = hit[DIR_RIGHT]  & cell_at(board, s + j);
      hit[DIR_DOWN]   = hit[DIR_DOWN]   & cell_at(board, s + j*N);
      hit[DIR_DIAG_R] = hit[DIR_DIAG_R] & cell_at(board, s + j*(N+1));
      hit[DIR_DIAG_L] = hit[DIR_DIAG_L] & cell_at(board, s + j*(N-1));
    end
  end

endmodule

// File: rtl/game_state_nxn.sv
// NxN X/O game-state register: validates moves, takes O from player or AI, scans for K-in-a-row.
// Latency: board bit next cycle; status N*N+1 cycles after an accepted move (busy during scan).
// Backpressure: ai_req gates AI offers; moves during scan/off-turn are dropped, after game end ignored.
module game_state_nxn
  import game_nxn_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int IW = $clog2(N*N)
) (
  input  logic           clk,
  input  logic           rst,
  game_state_nxn_if.slave gs
);

  localparam int CELLS = N*N;
  localparam int SW    = IW + 1;
  localparam logic [SW-1:0] CELLS_W  = SW'(CELLS);
  localparam logic [SW-1:0] LAST_IDX = SW'(CELLS - 1);

  fsm_t             state_q, state_d;
  logic [CELLS-1:0] x_q, x_d;
  logic [CELLS-1:0] o_q, o_d;
  status_t          status_q, status_d;
  mover_t           mover_q, mover_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic             hit_q, hit_d;
  logic             reject_q, reject_d;
  logic             ai_req_q, ai_req_d;
  logic             move_q;

  logic             move_edge;
  logic             offer;
  logic [IW-1:0]    cand;
  logic [CELLS-1:0] occupied;
  logic [CELLS-1:0] occ_sh;
  logic [CELLS-1:0] cand_bit;
  logic             legal;
  logic             board_full;
  logic [CELLS-1:0] scan_board;
  logic [NUM_DIRS-1:0] line_hit;
  logic             win_now;

  assign move_edge  = gs.move & ~move_q;
  assign occupied   = x_q | o_q;
  assign occ_sh     = occupied >> cand;
  assign cand_bit   = CELLS'(1) << cand;
  assign legal      = ({1'b0, cand} < CELLS_W) && !occ_sh[0];
  assign board_full = &occupied;
  assign scan_board = (mover_q == MOVER_O) ? o_q : x_q;

  line_checker #(
    .N  (N),
    .K  (K),
    .SW (SW)
  ) u_line_checker (
    .board (scan_board),
    .start (scan_q),
    .hit   (line_hit)
  );

  // Delayed copy of the player strobe for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) move_q <= 1'b0;
    else      move_q <= gs.move;
  end

  // Pick which source may offer a move this cycle; only the turn's own source is looked at.
  always_comb begin
    offer = 1'b0;
    cand  = gs.next_move;
    case (state_q)
      X_WAIT:  offer = move_edge;
      O_WAIT:  offer = move_edge & ~gs.ai_enable;
      AI_WAIT: begin
        offer = ai_req_q & gs.ai_move_valid;
        cand  = gs.ai_move;
      end
      default: offer = 1'b0;
    endcase
  end

  // Next-state and datapath updates: move validation, scan sequencing, outcome resolution.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    o_d      = o_q;
    status_d = status_q;
    mover_d  = mover_q;
    scan_d   = scan_q;
    hit_d    = hit_q;
    reject_d = 1'b0;
    ai_req_d = ai_req_q;
    win_now  = hit_q | (|line_hit);
    case (state_q)
      X_WAIT, O_WAIT, AI_WAIT: begin
        if (offer) begin
          if (legal) begin
            if (state_q == X_WAIT) begin
              x_d     = x_q | cand_bit;
              mover_d = MOVER_X;
            end else begin
              o_d     = o_q | cand_bit;
              mover_d = MOVER_O;
            end
            ai_req_d = 1'b0;
            scan_d   = '0;
            hit_d    = 1'b0;
            state_d  = SCAN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SCAN: begin
        hit_d = win_now;
        if (scan_q == LAST_IDX) begin
          if (win_now) begin
            status_d = win_status(mover_q);
            state_d  = DONE;
          end else if (board_full) begin
            status_d = DRAW;
            state_d  = DONE;
          end else if (mover_q == MOVER_X) begin
            status_d = O_TURN;
            // AI mode is decided once, on entry to O's turn.
            if (gs.ai_enable) begin
              state_d  = AI_WAIT;
              ai_req_d = 1'b1;
            end else begin
              state_d  = O_WAIT;
            end
          end else begin
            status_d = X_TURN;
            state_d  = X_WAIT;
          end
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = X_WAIT;
    endcase
  end

  // State and board registers; reset clears everything including a scan in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= X_WAIT;
      x_q      <= '0;
      o_q      <= '0;
      status_q <= X_TURN;
      mover_q  <= MOVER_X;
      scan_q   <= '0;
      hit_q    <= 1'b0;
      reject_q <= 1'b0;
      ai_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      o_q      <= o_d;
      status_q <= status_d;
      mover_q  <= mover_d;
      scan_q   <= scan_d;
      hit_q    <= hit_d;
      reject_q <= reject_d;
      ai_req_q <= ai_req_d;
    end
  end

  assign gs.x_state     = x_q;
  assign gs.o_state     = o_q;
  assign gs.game_status = status_q;
  assign gs.busy        = (state_q == SCAN);
  assign gs.move_reject = reject_q;
  assign gs.ai_req      = ai_req_q;

endmodule

// File: tb/tb_game_state_nxn.sv
// Bench for game_state_nxn: 3x3/K=3 and 5x5/K=4 instances against a board-array reference model.
// Latency: checks board at t+1, busy/old status at t+CELLS, new status at t+CELLS+1.
// Backpressure: exercises ai_req/ai_move_valid, rejects, ignored moves during scan and after game end.
module tb_game_state_nxn;
  import game_nxn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3;
  logic rst5;

  game_state_nxn_if #(.N(3)) g3 ();
  game_state_nxn_if #(.N(5)) g5 ();

  game_state_nxn #(.N(3), .K(3)) dut3 (.clk(clk), .rst(rst3), .gs(g3));
  game_state_nxn #(.N(5), .K(4)) dut5 (.clk(clk), .rst(rst5), .gs(g5));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: board[r*sn+c] = 0 empty, 1 X, 2 O.
  int         sel;
  int         sn;
  int         sk;
  int         board[64];
  int         turn;
  bit         over;
  bit         ai_en;
  bit         ai_mode;
  logic [2:0] mstat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_x();
    return (sel == 0) ? 64'(g3.x_state) : 64'(g5.x_state);
  endfunction
  function automatic logic [63:0] get_o();
    return (sel == 0) ? 64'(g3.o_state) : 64'(g5.o_state);
  endfunction
  function automatic logic [63:0] get_stat();
    return (sel == 0) ? 64'(g3.game_status) : 64'(g5.game_status);
  endfunction
  function automatic logic [63:0] get_busy();
    return (sel == 0) ? 64'(g3.busy) : 64'(g5.busy);
  endfunction
  function automatic logic [63:0] get_rej();
    return (sel == 0) ? 64'(g3.move_reject) : 64'(g5.move_reject);
  endfunction
  function automatic logic [63:0] get_req();
    return (sel == 0) ? 64'(g3.ai_req) : 64'(g5.ai_req);
  endfunction

  task automatic drv(input bit mv, input int nm, input bit av, input int am);
    if (sel == 0) begin
      g3.move = mv; g3.next_move = 4'(nm); g3.ai_move_valid = av; g3.ai_move = 4'(am);
    end else begin
      g5.move = mv; g5.next_move = 5'(nm); g5.ai_move_valid = av; g5.ai_move = 5'(am);
    end
  endtask

  task automatic set_rst(input bit v);
    if (sel == 0) rst3 = v;
    else          rst5 = v;
  endtask

  function automatic logic [63:0] mvec(input int p);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < sn*sn; i++) if (board[i] == p) v[i] = 1'b1;
    return v;
  endfunction

  // Any K-long straight line of player p, using 2-D coordinates.
  function automatic bit model_win(input int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < sn; r++)
      for (int c = 0; c < sn; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok;
          ok = 1'b1;
          for (int j = 0; j < sk; j++) begin
            int rr, cc;
            rr = r + j*dr[d];
            cc = c + j*dc[d];
            if (rr < 0 || rr >= sn || cc < 0 || cc >= sn) ok = 1'b0;
            else if (board[rr*sn + cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < sn*sn; i++) if (board[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_board(input string tag);
    check({tag, "_x"}, get_x(), mvec(1));
    check({tag, "_o"}, get_o(), mvec(2));
  endtask

  task automatic start_game(input int s, input bit ai);
    sel = s; sn = (s == 0) ? 3 : 5; sk = (s == 0) ? 3 : 4; ai_en = ai;
    if (s == 0) g3.ai_enable = ai;
    else        g5.ai_enable = ai;
    @(negedge clk);
    drv(1'b0, 0, 1'b0, 0);
    set_rst(1'b0);
    for (int i = 0; i < 64; i++) board[i] = 0;
    turn = 0; over = 1'b0; ai_mode = 1'b0; mstat = 3'b000;
    @(negedge clk);
    check("rst_x", get_x(), 0);
    check("rst_o", get_o(), 0);
    check("rst_stat", get_stat(), 0);
    check("rst_busy", get_busy(), 0);
    check("rst_rej", get_rej(), 0);
    check("rst_req", get_req(), 0);
    set_rst(1'b1);
  endtask

  // Offer one move on whichever port owns the turn; optional distractor on the other port.
  task automatic do_move(input int idx, input bit distract);
    int cells, alt;
    bit legal, use_ai;
    logic [2:0] old;
    cells  = sn*sn;
    use_ai = (turn == 1) && ai_mode;
    alt    = $urandom_range(0, cells - 1);
    @(negedge clk);
    if (use_ai) drv(distract, alt, 1'b1, idx);
    else        drv(1'b1, idx, distract, alt);
    @(negedge clk);
    drv(1'b0, 0, 1'b0, 0);
    if (over) begin
      check("done_rej", get_rej(), 0);
      check_board("done");
      check("done_stat", get_stat(), 64'(mstat));
      return;
    end
    legal = (idx < cells) && (board[idx] == 0);
    check("reject", get_rej(), legal ? 64'd0 : 64'd1);
    if (!legal) begin
      check_board("rej");
      check("rej_stat", get_stat(), 64'(mstat));
      check("rej_req", get_req(), use_ai ? 64'd1 : 64'd0);
      return;
    end
    board[idx] = turn + 1;
    check_board("mv");
    check("mv_busy", get_busy(), 1);
    check("mv_req", get_req(), 0);
    old = mstat;
    for (int c = 2; c <= cells; c++) begin
      @(negedge clk);
      if (distract && c == 2) drv(1'b1, alt, 1'b1, alt);
      if (c == 3) drv(1'b0, 0, 1'b0, 0);
    end
    check("scan_busy", get_busy(), 1);
    check("scan_stat", get_stat(), 64'(old));
    check("scan_req", get_req(), 0);
    @(negedge clk);
    if (model_win(turn + 1)) begin
      mstat = (turn == 1) ? 3'b011 : 3'b010; over = 1'b1;
    end else if (model_full()) begin
      mstat = 3'b100; over = 1'b1;
    end else begin
      turn  = 1 - turn;
      mstat = (turn == 1) ? 3'b001 : 3'b000;
      if (turn == 1) ai_mode = ai_en;
    end
    check("end_stat", get_stat(), 64'(mstat));
    check("end_busy", get_busy(), 0);
    check("end_req", get_req(), (!over && turn == 1 && ai_mode) ? 64'd1 : 64'd0);
    check_board("end");
  endtask

  initial begin
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_diag[7] = '{0, 1, 6, 2, 12, 3, 18};
    int seq_wrap[7] = '{3, 10, 4, 11, 5, 20, 6};
    sel = 0;
    rst3 = 1'b0; rst5 = 1'b0;
    g3.move = 0; g3.next_move = '0; g3.ai_enable = 0; g3.ai_move_valid = 0; g3.ai_move = '0;
    g5.move = 0; g5.next_move = '0; g5.ai_enable = 0; g5.ai_move_valid = 0; g5.ai_move = '0;
    repeat (2) @(negedge clk);

    // X top-row win, then a move after the game is over.
    start_game(0, 1'b0);
    do_move(0, 1'b0); do_move(3, 1'b0); do_move(1, 1'b0); do_move(4, 1'b0); do_move(2, 1'b0);
    check("top_x", get_x(), 64'h007);
    check("top_o", get_o(), 64'h018);
    check("top_stat", get_stat(), 64'h2);
    do_move(5, 1'b1);

    // Occupied and out-of-range rejects for O.
    start_game(0, 1'b0);
    do_move(0, 1'b0); do_move(0, 1'b0); do_move(9, 1'b0);
    check("rej_o_state", get_o(), 0);
    check("rej_o_stat", get_stat(), 64'h1);

    // AI handshake: occupied AI move rejected, then a good one.
    start_game(0, 1'b1);
    do_move(4, 1'b0); do_move(4, 1'b0); do_move(0, 1'b0);
    check("ai_o_state", get_o(), 64'h001);

    // Draw.
    start_game(0, 1'b0);
    foreach (seq_draw[i]) do_move(seq_draw[i], 1'b0);
    check("draw_stat", get_stat(), 64'h4);

    // 5x5, K=4: diagonal win and a row-wrapping non-win.
    start_game(1, 1'b0);
    foreach (seq_diag[i]) do_move(seq_diag[i], 1'b0);
    check("diag_stat", get_stat(), 64'h2);
    start_game(1, 1'b0);
    foreach (seq_wrap[i]) do_move(seq_wrap[i], 1'b0);
    check("wrap_stat", get_stat(), 64'h1);

    // Reset mid-scan with move held across release: exactly one move taken.
    start_game(0, 1'b0);
    @(negedge clk); drv(1'b1, 4, 1'b0, 0);
    @(negedge clk); drv(1'b0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    drv(1'b1, 4, 1'b0, 0);
    set_rst(1'b0);
    @(negedge clk);
    check("mid_x", get_x(), 0);
    check("mid_busy", get_busy(), 0);
    check("mid_stat", get_stat(), 0);
    set_rst(1'b1);
    repeat (15) @(negedge clk);
    check("held_x", get_x(), 64'h010);
    check("held_o", get_o(), 0);
    check("held_stat", get_stat(), 64'h1);
    drv(1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 64; i++) board[i] = 0;
    board[4] = 1; turn = 1; mstat = 3'b001; over = 1'b0; ai_mode = 1'b0;
    do_move(0, 1'b1);

    // Random games on both boards, including illegal indices and distractors.
    for (int g = 0; g < 24; g++) begin
      int span;
      start_game(g % 2, 1'($urandom_range(0, 1)));
      span = (sel == 0) ? 15 : 31;
      for (int a = 0; a < 50 && !over; a++) begin
        int idx;
        idx = ($urandom_range(0, 99) < 15) ? $urandom_range(0, span) : $urandom_range(0, sn*sn - 1);
        do_move(idx, 1'($urandom_range(0, 1)));
      end
      if (over) do_move($urandom_range(0, sn*sn - 1), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
